axi_hp_frame_wr: RTL and testbench
==================================

# axi_hp_frame_wr

Parametrised AXI3/AXI4 HP write master that moves one frame of an AXI-Stream input into DDR through a Zynq HP port, splitting the frame into bursts of configurable length. It sits between the PL data source (FIFO) and the PS HP slave. It generalises the single fixed 4-beat write path with:
- parametrised data width and burst length,
- a runtime base address and frame length,
- a short final burst,
- write-response checking,
- optional byte swapping.

## Interface
- DATA_WIDTH, 64: AXI/stream data width in bits; one of 32, 64, 128.
- ADDR_WIDTH, 32: AXI address width.
- BURST_LEN, 16: maximum beats per burst, 1..256. BURST_LEN*DATA_WIDTH/8 must be ≤ 4096 and a power of two.
- SWAP_BYTES, 0: 1 reverses byte order within each beat (big↔little endian).
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that starts a frame; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  frame start byte address; the low log2(BURST_LEN*DATA_WIDTH/8) bits are forced to 0.
- i_frame_beats  in  24  frame length in beats; 0 means no transfer.
- S_WR_tdata  in  DATA_WIDTH  stream data.
- S_WR_tvalid  in  1  stream valid.
- S_WR_tlast  in  1  stream frame end marker; checked only, never used to end the frame.
- S_WR_tready  out  1  stream ready.
- o_busy  out  1  high from start acceptance until o_done.
- o_done  out  1  one-cycle pulse when the frame is complete.
- o_err  out  1  sticky error flag; cleared on the next accepted i_start.
- o_bresp_err_cnt  out  8  saturating count of non-OKAY BRESP; cleared on the next accepted i_start.
- m_axi_awaddr  out  ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  burst beats minus 1.
- m_axi_awsize  out  3  constant log2(DATA_WIDTH/8).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wstrb  out  DATA_WIDTH/8  write strobe; all ones.
- m_axi_wlast  out  1  last beat of the burst.
- m_axi_wvalid  out  1  write valid.
- m_axi_wready  in  1  write ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- ID, lock, cache, prot, qos and user signals are tied off at the wrapper and are not ports of this block.

## Operation
States: IDLE, ADDR, DATA, RESP, DONE.

**IDLE**
- i_start with i_frame_beats≠0: latch the aligned address and the beat count, clear o_err and o_bresp_err_cnt, go to ADDR.
- i_start with i_frame_beats=0: no AXI activity; go to DONE.

**ADDR**
- Burst size: beats = min(BURST_LEN, remaining).
- Drive m_axi_awvalid=1 with m_axi_awlen = beats-1.
- On awvalid&awready, go to DATA.

**DATA**
- Connections: m_axi_wvalid = S_WR_tvalid, S_WR_tready = m_axi_wready, m_axi_wdata = S_WR_tdata (byte-reversed if SWAP_BYTES). These are combinational, giving zero-bubble pass-through.
- A beat transfers on wvalid&wready.
- m_axi_wlast = (beat_cnt == beats-1).
- After the wlast beat, go to RESP.

**RESP**
- m_axi_bready=1.
- On bvalid: if bresp≠2'b00, set o_err and increment o_bresp_err_cnt (saturating at 255).
- Then: remaining≠0 → address += beats*DATA_WIDTH/8, go to ADDR; otherwise go to DONE.

**DONE**
- o_done=1 for one cycle, then IDLE.

**tlast check**
- S_WR_tlast=1 on a beat that is not the frame's final beat, or 0 on the final beat, sets o_err.
- The transfer continues to the programmed beat count regardless.

**Arithmetic and boundaries**
- The remaining counter is 24 bits and decrements by beats on each accepted response.
- The address is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
- Alignment plus the parameter constraint guarantee no burst crosses a 4 KB boundary.

## Timing
- Reset: all outputs 0 except constants (awsize, awburst, wstrb); state IDLE; counters 0.
- Reset mid-frame abandons the transaction immediately; there is no AXI cleanup.
- Latency:
  - i_start to awvalid: 1 cycle.
  - awready to first possible W beat: 1 cycle.
  - bvalid to the next awvalid: 1 cycle.
- awvalid, once high, holds with stable awaddr and awlen until awready.
- W is never driven before the matching AW is accepted.
- Only one burst is outstanding at a time.
- S_WR_tready=0 in every state except DATA.
- m_axi_bready=0 outside RESP.
- i_start is ignored while o_busy=1.
- o_busy falls in the same cycle that o_done pulses.

## Test plan
- **Basic frame:** BURST_LEN=16, base 0x1000_0000, frame 16 beats, always-ready slave → one AW (awlen=15); 16 W beats with wlast on beat 16; o_done 1 cycle after bvalid; o_err=0.
- **Short final burst:** frame 40 beats → awaddr 0x1000_0000/0x1000_0080/0x1000_0100 with awlen 15/15/7 (64-bit data).
- **Backpressure:** random wready and tvalid gaps, awready delayed 5 cycles → no data lost or duplicated; awaddr and awlen stable while waiting.
- **Error response:** bresp=2'b10 on burst 2 of 3 → o_err=1, o_bresp_err_cnt=1; the frame still completes.
- **Early tlast:** tlast on beat 10 of 16 → o_err=1, 16 beats still written. With SWAP_BYTES=1, tdata 0x0011223344556677 → wdata 0x7766554433221100.
- **Reset and degenerate cases:** i_rst asserted mid-burst → the cycle after, all outputs 0 and state IDLE. i_frame_beats=0 → o_done pulse with no awvalid. i_start while busy → ignored.

Source files
------------

// File: rtl/axi_hp_frame_wr.sv
// AXI3/AXI4 HP write master: moves one AXI-Stream frame into memory as aligned
// INCR bursts of up to BURST_LEN beats. One burst is outstanding at a time, and BRESP is checked.
//
// state  | meaning
// IDLE   | waiting for i_start
// ADDR   | presenting the AW for the current burst
// DATA   | streaming W beats straight from the input stream
// RESP   | waiting for the burst's B response
// DONE   | one-cycle o_done pulse
module axi_hp_frame_wr #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int SWAP_BYTES = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [23:0]             i_frame_beats,
    input  logic [DATA_WIDTH-1:0]   S_WR_tdata,
    input  logic                    S_WR_tvalid,
    input  logic                    S_WR_tlast,
    output logic                    S_WR_tready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [7:0]              o_bresp_err_cnt,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int SIZE_LOG2  = $clog2(BYTES);
    localparam int ALIGN_BITS = $clog2(BURST_LEN * BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [23:0]             remaining;
    logic [8:0]              beat_cnt;
    logic                    err;
    logic [7:0]              err_cnt;
    logic [8:0]              beats;
    logic [8:0]              beats_m1;
    logic                    last_burst;
    logic                    in_data;
    logic                    w_fire;
    logic                    wlast_int;
    logic [DATA_WIDTH-1:0]   data_fmt;

    // remaining < BURST_LEN <= 256 whenever it is selected, so 9 bits hold it
    assign beats      = (remaining >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : remaining[8:0];
    assign beats_m1   = beats - 9'd1;
    assign last_burst = (remaining <= 24'(BURST_LEN));
    assign in_data    = (state == S_DATA);
    assign w_fire     = in_data && S_WR_tvalid && m_axi_wready;
    assign wlast_int  = (beat_cnt == beats_m1);

    generate
        if (SWAP_BYTES != 0) begin : g_swap
            for (genvar b = 0; b < BYTES; b++) begin : g_byte
                assign data_fmt[b*8 +: 8] = S_WR_tdata[(BYTES-1-b)*8 +: 8];
            end
        end else begin : g_noswap
            assign data_fmt = S_WR_tdata;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_start) state_nxt = (i_frame_beats != 24'd0) ? S_ADDR : S_DONE;
            S_ADDR: if (m_axi_awready) state_nxt = S_DATA;
            S_DATA: if (w_fire && wlast_int) state_nxt = S_RESP;
            S_RESP: if (m_axi_bvalid) state_nxt = last_burst ? S_DONE : S_ADDR;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    addr      <= i_base_addr & ALIGN_MASK;
                    remaining <= i_frame_beats;
                    beat_cnt  <= '0;
                    err       <= 1'b0;
                    err_cnt   <= '0;
                end
                S_DATA: if (w_fire) begin
                    beat_cnt <= wlast_int ? 9'd0 : beat_cnt + 9'd1;
                    // tlast is only audited; the programmed count ends the frame
                    if (S_WR_tlast != (wlast_int && last_burst)) err <= 1'b1;
                end
                S_RESP: if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                    remaining <= remaining - 24'(beats);
                    addr      <= addr + (ADDR_WIDTH'(beats) << SIZE_LOG2);
                end
                default: ;
            endcase
        end
    end

    assign m_axi_awvalid   = (state == S_ADDR);
    assign m_axi_awaddr    = m_axi_awvalid ? addr : '0;
    assign m_axi_awlen     = m_axi_awvalid ? beats_m1[7:0] : 8'd0;
    assign m_axi_awsize    = 3'(SIZE_LOG2);
    assign m_axi_awburst   = 2'b01;
    assign m_axi_wstrb     = '1;
    assign m_axi_wvalid    = in_data && S_WR_tvalid;
    assign S_WR_tready     = in_data && m_axi_wready;
    assign m_axi_wdata     = in_data ? data_fmt : '0;
    assign m_axi_wlast     = in_data && wlast_int;
    assign m_axi_bready    = (state == S_RESP);
    assign o_busy          = (state == S_ADDR) || (state == S_DATA) || (state == S_RESP);
    assign o_done          = (state == S_DONE);
    assign o_err           = err;
    assign o_bresp_err_cnt = err_cnt;

endmodule

// File: tb/tb_axi_hp_frame_wr.sv
// Scoreboard bench for axi_hp_frame_wr (64-bit data, 16-beat bursts, byte swap on):
// expected AW/W traffic is queued at stimulus time, and a negedge monitor pops and compares it.
module tb_axi_hp_frame_wr;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [23:0] i_frame_beats = '0;
    logic [63:0] S_WR_tdata = '0;
    logic        S_WR_tvalid = 1'b0;
    logic        S_WR_tlast = 1'b0;
    logic        S_WR_tready;
    logic        o_busy, o_done, o_err;
    logic [7:0]  o_bresp_err_cnt;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    axi_hp_frame_wr #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN(16), .SWAP_BYTES(1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_frame_beats(i_frame_beats), .S_WR_tdata(S_WR_tdata), .S_WR_tvalid(S_WR_tvalid),
        .S_WR_tlast(S_WR_tlast), .S_WR_tready(S_WR_tready), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_bresp_err_cnt(o_bresp_err_cnt), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_aw[$];
    logic [64:0] exp_w[$];

    // stimulus configuration shared with the source/slave driver
    logic [63:0] src_data[64];
    int src_n = 0;
    int tlast_pos = -1;
    int err_burst = -1;
    bit bp = 1'b0;
    int aw_delay = 0;
    int frame_id = 0;
    logic [7:0] exp_err_cnt;
    logic exp_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor
    initial begin
        logic        aw_hold = 1'b0;
        logic [39:0] aw_held = '0;
        logic        done_due = 1'b0;
        logic [39:0] ea;
        logic [64:0] ew;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                aw_hold  = 1'b0;
                done_due = 1'b0;
            end else begin
                if (done_due) begin
                    chk("done_lat", 64'(o_done), 64'd1);
                    chk("busy_at_done", 64'(o_busy), 64'd0);
                    done_due = 1'b0;
                end
                if (aw_hold)
                    chk("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, aw_held});
                aw_hold = m_axi_awvalid && !m_axi_awready;
                aw_held = {m_axi_awaddr, m_axi_awlen};
                if (m_axi_awvalid && m_axi_awready) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                    else begin
                        ea = exp_aw.pop_front();
                        chk("awaddr", 64'(m_axi_awaddr), 64'(ea[39:8]));
                        chk("awlen", 64'(m_axi_awlen), 64'(ea[7:0]));
                    end
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                    else begin
                        ew = exp_w.pop_front();
                        chk("wdata", m_axi_wdata, ew[63:0]);
                        chk("wlast", 64'(m_axi_wlast), 64'(ew[64]));
                    end
                end
                if (m_axi_bvalid && m_axi_bready && exp_aw.size() == 0) done_due = 1'b1;
            end
        end
    end

    // stream source and AXI slave model
    initial begin
        bit s_fire, wl_fire, b_fire;
        int src_idx = 0;
        int burst_idx = 0;
        int aw_wait = 0;
        int seen_id = 0;
        forever begin
            @(negedge clk);
            s_fire  = S_WR_tvalid && S_WR_tready;
            wl_fire = m_axi_wvalid && m_axi_wready && m_axi_wlast;
            b_fire  = m_axi_bvalid && m_axi_bready;
            @(posedge clk);
            #1;
            if (seen_id != frame_id) begin
                seen_id   = frame_id;
                src_idx   = 0;
                burst_idx = 0;
                s_fire    = 1'b0;
            end
            if (s_fire) src_idx++;
            if (src_idx < src_n) begin
                if (!(S_WR_tvalid && !s_fire)) S_WR_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                S_WR_tdata = src_data[src_idx];
                S_WR_tlast = (src_idx == tlast_pos);
            end else begin
                S_WR_tvalid = 1'b0;
                S_WR_tlast  = 1'b0;
            end
            m_axi_wready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (i_rst) begin
                m_axi_bvalid  = 1'b0;
                m_axi_awready = 1'b0;
                aw_wait       = 0;
            end else begin
                if (m_axi_awvalid) begin
                    aw_wait++;
                    m_axi_awready = (aw_wait > aw_delay);
                end else begin
                    aw_wait       = 0;
                    m_axi_awready = 1'b0;
                end
                if (b_fire) m_axi_bvalid = 1'b0;
                if (wl_fire) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
                    burst_idx++;
                end
            end
        end
    end

    task automatic setup_frame(input logic [31:0] base, input int n, input int tl, input int eb,
                               input bit bpi, input int dly);
        logic [31:0] a;
        int rem, len, nb;
        @(negedge clk);
        frame_id++;
        for (int i = 0; i < n; i++) begin
            src_data[i] = 64'h0011223344556677 ^ {48'h0, 8'(frame_id), 8'(i)};
            exp_w.push_back({((i % 16) == 15) || (i == n - 1),
                             64'h7766554433221100 ^ {8'(i), 8'(frame_id), 48'h0}});
        end
        a = base & 32'hFFFF_FF80;
        rem = n;
        nb = 0;
        while (rem > 0) begin
            len = (rem > 16) ? 16 : rem;
            exp_aw.push_back({a, 8'(len - 1)});
            a = a + 32'(len * 8);
            rem = rem - len;
            nb++;
        end
        exp_err_cnt = (eb >= 0 && eb < nb) ? 8'd1 : 8'd0;
        exp_err     = (exp_err_cnt != 0) || (n != 0 && tl != n - 1);
        src_n = n; tlast_pos = tl; err_burst = eb; bp = bpi; aw_delay = dly;
        @(posedge clk); #1;
        i_base_addr = base; i_frame_beats = 24'(n); i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        if (n != 0) chk("aw_lat", 64'(m_axi_awvalid), 64'd1);
    endtask

    task automatic finish_frame(input int n);
        bit got = 1'b0;
        if (n == 0) got = o_done;
        else begin
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (o_done) begin got = 1'b1; break; end
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("err", 64'(o_err), 64'(exp_err));
        chk("bresp_cnt", 64'(o_bresp_err_cnt), 64'(exp_err_cnt));
        chk("aw_left", 64'(exp_aw.size()), 64'd0);
        chk("w_left", 64'(exp_w.size()), 64'd0);
        @(negedge clk);
        chk("done_pulse", {o_done, o_busy}, 64'd0);
        exp_aw.delete();
        exp_w.delete();
    endtask

    task automatic run_frame(input logic [31:0] base, input int n, input int tl, input int eb,
                             input bit bpi, input int dly, input bit busy_start);
        setup_frame(base, n, tl, eb, bpi, dly);
        if (busy_start) begin
            repeat (3) @(negedge clk);
            chk("busy_flag", 64'(o_busy), 64'd1);
            @(posedge clk); #1;
            i_base_addr = 32'h0; i_frame_beats = 24'd5; i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        finish_frame(n);
    endtask

    initial begin
        bit reached;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {S_WR_tready, o_busy, o_done, o_err, o_bresp_err_cnt, m_axi_awvalid,
                            m_axi_awaddr, m_axi_awlen, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 64'd0);
        chk("rst_wdata", m_axi_wdata, 64'd0);
        chk("rst_consts", {m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {3'd3, 2'b01, 8'hFF});
        @(posedge clk); #1;
        i_rst = 1'b0;

        run_frame(32'h1000_0000, 16, 15, -1, 1'b0, 0, 1'b0);   // basic
        run_frame(32'h1000_003C, 40, 39, -1, 1'b0, 0, 1'b0);   // short final burst, unaligned base
        run_frame(32'h2000_0100, 40, 39, -1, 1'b1, 5, 1'b0);   // backpressure
        run_frame(32'h3000_0000, 40, 39,  1, 1'b0, 0, 1'b0);   // BRESP error on burst 2
        run_frame(32'h1000_0000, 16,  9, -1, 1'b0, 0, 1'b0);   // early tlast
        run_frame(32'h4000_0000,  0, -1, -1, 1'b0, 0, 1'b0);   // zero-length frame
        run_frame(32'h5000_0000, 16, 15, -1, 1'b1, 2, 1'b1);   // start while busy
        run_frame(32'hFFFF_FF80, 32, 31, -1, 1'b0, 0, 1'b0);   // address wrap

        // reset mid-frame
        setup_frame(32'h6000_0000, 40, 39, -1, 1'b0, 0);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (exp_w.size() <= 25) begin reached = 1'b1; break; end
        end
        chk("mid_frame_reached", 64'(reached), 64'd1);
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {S_WR_tready, o_busy, o_done, o_err, o_bresp_err_cnt, m_axi_awvalid,
                               m_axi_awaddr, m_axi_awlen, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 64'd0);
        chk("midrst_wdata", m_axi_wdata, 64'd0);
        exp_aw.delete();
        exp_w.delete();
        src_n = 0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(32'h7000_0080, 20, 19, -1, 1'b1, 1, 1'b0);   // recovery after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
